// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one valid/ready memory port (picorv32 style) between two bus
// masters: master 0 (normally the CPU) and master 1 (a DMA engine, text
// renderer or similar). Requests are granted one at a time, round-robin.
// The granted master's request is muxed onto the slave port, and the slave's
// ready/rdata is returned to that master only. Every completed or abandoned
// transfer passes through one IDLE cycle before the next grant.
//
// Optional feature (compile-time macro MEM_ARB_TIMEOUT_EN):
//   When defined, a grant that waits TIMEOUT_CYCLES cycles without s_ready is
//   terminated. The master gets a ready pulse with rdata = 32'hFFFF_FFFF, and
//   the sticky timeout_err flag is set until reset. When the macro is not
//   defined, no counter is built, timeout_err is tied low and a grant waits
//   for s_ready indefinitely.
//
// Parameters:
//   TIMEOUT_CYCLES  slave wait limit in cycles (used only with the macro)
//
// Ports:
//   clk, reset                    clock; asynchronous active-high reset
//   m0_valid/addr/wdata/wstrb     master 0 request (wstrb == 0 means read)
//   m0_ready, m0_rdata            master 0 completion pulse and read data
//   m1_*                          same set for master 1
//   s_valid/addr/wdata/wstrb      request forwarded to the slave
//   s_ready, s_rdata              slave completion and read data
//   grant                         one-hot owner: 01 = m0, 10 = m1, 00 = none
//   timeout_err                   sticky timeout flag
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,

  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,

  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e state_q, state_d;

  // last_q = 1 means master 1 was the most recent completed owner, so master 0
  // wins the next tie. Reset to 1 so that m0 wins the very first tie.
  logic last_q, last_d;

  // valid of whichever master currently owns the port (0 in IDLE)
  logic sel_valid;

  // terminate the current grant this cycle because the slave never answered
  logic to_hit;

  always_comb begin
    sel_valid = 1'b0;
    case (state_q)
      GNT0:    sel_valid = m0_valid;
      GNT1:    sel_valid = m1_valid;
      default: sel_valid = 1'b0;
    endcase
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // A real completion in the limit cycle takes priority over the timeout,
  // and a master that has already dropped valid is an abort, not a timeout.
  assign to_hit = (state_q != IDLE) && sel_valid && !s_ready &&
                  (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Counter is held at zero in IDLE, so it starts from zero on every grant.
  // It cannot wrap: reaching the limit always ends the grant.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (!s_ready) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign err_d = err_q | to_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;

  // TIMEOUT_CYCLES has no effect without the timeout feature
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          // tie: serve the master that was not served last
          state_d = last_q ? GNT0 : GNT1;
        end else if (m0_valid) begin
          state_d = GNT0;
        end else if (m1_valid) begin
          state_d = GNT1;
        end
      end
      GNT0, GNT1: begin
        if (!sel_valid) begin
          // owner withdrew its request: abandon without touching fairness
          state_d = IDLE;
        end else if (s_ready || to_hit) begin
          state_d = IDLE;
          last_d  = (state_q == GNT1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: slave request mux and master response steering
  // ---------------------------------------------------------------------------
  always_comb begin
    grant    = 2'b00;
    s_valid  = 1'b0;
    s_addr   = 32'h0;
    s_wdata  = 32'h0;
    s_wstrb  = 4'h0;
    m0_ready = 1'b0;
    m0_rdata = 32'h0;
    m1_ready = 1'b0;
    m1_rdata = 32'h0;
    case (state_q)
      GNT0: begin
        grant    = 2'b01;
        s_valid  = m0_valid && !to_hit;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_wstrb  = m0_wstrb;
        m0_ready = s_ready || to_hit;
        m0_rdata = to_hit ? 32'hFFFF_FFFF : s_rdata;
      end
      GNT1: begin
        grant    = 2'b10;
        s_valid  = m1_valid && !to_hit;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_wstrb  = m1_wstrb;
        m1_ready = s_ready || to_hit;
        m1_rdata = to_hit ? 32'hFFFF_FFFF : s_rdata;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Randomized and directed stimulus for mem_arbiter. A reference model tracks
// the current owner (-1 = nobody, 0, 1) and the last served master as plain
// integers, predicts every output each cycle and is compared against the DUT.
// Grant order, fairness bound, timeout latency and async reset are also
// checked directly on the observed DUT outputs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;

  logic        mv [2];
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic [3:0]  ms [2];

  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        timeout_err;

  assign m0_valid = mv[0];
  assign m0_addr  = ma[0];
  assign m0_wdata = mw[0];
  assign m0_wstrb = ms[0];
  assign m1_valid = mv[1];
  assign m1_addr  = ma[1];
  assign m1_wdata = mw[1];
  assign m1_wstrb = ms[1];

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .m0_valid   (m0_valid),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_wstrb   (m0_wstrb),
    .m0_ready   (m0_ready),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_ready   (m1_ready),
    .m1_rdata   (m1_rdata),
    .s_valid    (s_valid),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_ready    (s_ready),
    .s_rdata    (s_rdata),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int   owner;
  int   last_m;
  int   tcnt;
  bit   err_m;
  // slave and master behaviour knobs
  int   lat;
  int   fixed_lat;
  bit   mute;
  bit   use_fix;
  logic [31:0] fix_rdata;
  bit   hold_mode;
  // observations from the last cycle
  logic        obs_rdy [2];
  logic [31:0] obs_rd0;
  logic [1:0]  obs_grant;
  int          done_q [$];
  int          wait_c [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic new_req(input int i);
    ma[i] = $urandom;
    mw[i] = $urandom;
    ms[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    mv[i] = 1'b1;
  endtask

  task automatic new_wr(input int i);
    ma[i] = $urandom;
    mw[i] = $urandom;
    ms[i] = 4'($urandom_range(1, 15));
    mv[i] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mv[0] = 1'b0;
    mv[1] = 1'b0;
    s_ready = 1'b0;
    owner = -1;
    last_m = 1;
    tcnt = 0;
    err_m = 1'b0;
    lat = 0;
    wait_c[0] = 0;
    wait_c[1] = 0;
    done_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock cycle: choose slave response, compare all outputs against the
  // model, advance the model across the edge, then update master behaviour.
  task automatic cycle();
    logic        tohit;
    logic [1:0]  eg;
    logic        esv;
    logic [31:0] ea, ew;
    logic [3:0]  es;
    logic        ery [2];
    logic [31:0] erd [2];
    int          n_owner, n_last, n_tcnt;
    bit          n_err;

    if (owner >= 0 && mv[owner]) begin
      s_ready = (!mute && lat == 0);
      s_rdata = (s_ready && use_fix) ? fix_rdata : $urandom;
    end else if (owner >= 0) begin
      s_ready = 1'b0;
      s_rdata = $urandom;
    end else begin
      // nobody granted: slave noise must not reach either master
      s_ready = 1'($urandom_range(0, 1));
      s_rdata = $urandom;
    end
    #1;

    tohit = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    if (owner >= 0 && mv[owner] && !s_ready && tcnt == TO) tohit = 1'b1;
`endif
    eg = 2'b00; esv = 1'b0; ea = 32'h0; ew = 32'h0; es = 4'h0;
    ery[0] = 1'b0; ery[1] = 1'b0; erd[0] = 32'h0; erd[1] = 32'h0;
    if (owner >= 0) begin
      eg = 2'(1 << owner);
      esv = mv[owner] && !tohit;
      ea = ma[owner];
      ew = mw[owner];
      es = ms[owner];
      ery[owner] = s_ready || tohit;
      erd[owner] = tohit ? 32'hFFFF_FFFF : s_rdata;
    end

    check("grant",    32'(grant),       32'(eg));
    check("s_valid",  32'(s_valid),     32'(esv));
    check("s_addr",   s_addr,           ea);
    check("s_wdata",  s_wdata,          ew);
    check("s_wstrb",  32'(s_wstrb),     32'(es));
    check("m0_ready", 32'(m0_ready),    32'(ery[0]));
    check("m0_rdata", m0_rdata,         erd[0]);
    check("m1_ready", 32'(m1_ready),    32'(ery[1]));
    check("m1_rdata", m1_rdata,         erd[1]);
    check("tmo_err",  32'(timeout_err), 32'(err_m));

    obs_rdy[0] = m0_ready;
    obs_rdy[1] = m1_ready;
    obs_rd0    = m0_rdata;
    obs_grant  = grant;

    n_owner = owner; n_last = last_m; n_tcnt = tcnt; n_err = err_m;
    if (owner < 0) begin
      if (mv[0] && mv[1])  n_owner = 1 - last_m;
      else if (mv[0])      n_owner = 0;
      else if (mv[1])      n_owner = 1;
      n_tcnt = 0;
    end else if (!mv[owner]) begin
      n_owner = -1;
    end else if (s_ready) begin
      n_owner = -1;
      n_last = owner;
    end else if (tohit) begin
      n_owner = -1;
      n_last = owner;
      n_err = 1'b1;
    end else begin
      n_tcnt = tcnt + 1;
    end

    @(posedge clk);
    #1;
    if (owner < 0 && n_owner >= 0)
      lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
    else if (owner >= 0 && n_owner >= 0 && lat > 0)
      lat--;
    owner = n_owner; last_m = n_last; tcnt = n_tcnt; err_m = n_err;

    for (int i = 0; i < 2; i++) begin
      if (obs_rdy[i]) done_q.push_back(i);
      if (ery[i]) begin
        if (hold_mode) new_req(i);
        else mv[i] = 1'b0;
      end
    end
    // a waiting master may see at most one transfer of the other master
    for (int i = 0; i < 2; i++) begin
      if (!mv[i] || obs_grant[i]) begin
        wait_c[i] = 0;
      end else if (obs_rdy[1 - i]) begin
        wait_c[i]++;
        check("rr_bound", 32'(wait_c[i] <= 1), 32'd1);
      end
    end
  endtask

  initial begin
    int npulse;
    int base;
    int c;
    bit got;

    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mv[i] = 1'b0; ma[i] = 32'h0; mw[i] = 32'h0; ms[i] = 4'h0;
    end
    s_ready = 1'b0; s_rdata = 32'h0;
    mute = 1'b0; use_fix = 1'b0; fix_rdata = 32'h0; hold_mode = 1'b0;
    fixed_lat = -1;
    do_reset();

    // reset state, with slave noise on s_ready
    repeat (3) cycle();

    // single read, slave answers two cycles after s_valid
    fixed_lat = 2; use_fix = 1'b1; fix_rdata = 32'h1234_5678;
    ma[0] = 32'h0000_0010; mw[0] = $urandom; ms[0] = 4'h0; mv[0] = 1'b1;
    npulse = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (obs_rdy[0]) begin
        npulse++;
        check("rd_rdata", obs_rd0, 32'h1234_5678);
      end
    end
    check("rd_pulses", 32'(npulse), 32'd1);
    use_fix = 1'b0;

    // simultaneous writes straight out of reset
    do_reset();
    fixed_lat = -1;
    new_wr(0);
    new_wr(1);
    for (int k = 0; k < 30 && done_q.size() < 2; k++) cycle();
    check("sim_cnt", 32'(done_q.size()), 32'd2);
    if (done_q.size() == 2) begin
      check("sim_first",  32'(done_q[0]), 32'd0);
      check("sim_second", 32'(done_q[1]), 32'd1);
    end

    // fairness with both masters requesting continuously
    do_reset();
    hold_mode = 1'b1;
    new_req(0);
    new_req(1);
    for (int k = 0; k < 100 && done_q.size() < 6; k++) cycle();
    hold_mode = 1'b0;
    mv[0] = 1'b0;
    mv[1] = 1'b0;
    check("fair_cnt", 32'(done_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < done_q.size(); i++)
      check("fair_order", 32'(done_q[i]), 32'(i % 2));
    repeat (2) cycle();

    // abort: m0 served first so the next tie should favour m1
    fixed_lat = 0;
    base = done_q.size();
    new_req(0);
    for (int k = 0; k < 10 && done_q.size() == base; k++) cycle();
    check("abort_pre", 32'(done_q.size()), 32'(base + 1));
    mute = 1'b1;
    new_req(1);
    npulse = 0;
    repeat (3) begin cycle(); npulse += int'(obs_rdy[1]); end
    check("abort_gnt", 32'(obs_grant), 32'b10);
    mv[1] = 1'b0;
    repeat (2) begin cycle(); npulse += int'(obs_rdy[1]); end
    check("abort_noready", 32'(npulse), 32'd0);
    check("abort_idle", 32'(obs_grant), 32'd0);
    mute = 1'b0;
    fixed_lat = 1;
    new_req(0);
    new_req(1);
    cycle();
    cycle();
    check("abort_tie", 32'(obs_grant), 32'b10);
    base = done_q.size();
    for (int k = 0; k < 20 && done_q.size() < base + 2; k++) cycle();
    check("abort_tie_done", 32'(done_q.size()), 32'(base + 2));

`ifdef MEM_ARB_TIMEOUT_EN
    // silent slave: m0 read must time out TO cycles into the grant
    mute = 1'b1;
    new_req(0);
    ms[0] = 4'h0;
    cycle();
    c = 0;
    got = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cycle();
      if (obs_rdy[0]) begin got = 1'b1; break; end
      c++;
    end
    check("to_seen",  32'(got), 32'd1);
    check("to_lat",   32'(c), 32'(TO));
    check("to_rdata", obs_rd0, 32'hFFFF_FFFF);
    check("to_err",   32'(timeout_err), 32'd1);
    mute = 1'b0;
    fixed_lat = 1;
    new_req(1);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (obs_rdy[1]) begin got = 1'b1; break; end
    end
    check("to_m1_served", 32'(got), 32'd1);
    check("to_err_held",  32'(timeout_err), 32'd1);
    repeat (2) cycle();
`endif

    // reset in the middle of an m0 grant with the slave silent
    mute = 1'b1;
    new_req(0);
    repeat (3) cycle();
    check("prerst_svalid", 32'(s_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_svalid", 32'(s_valid), 32'd0);
    check("rst_grant",  32'(grant), 32'd0);
    check("rst_m0rdy",  32'(m0_ready), 32'd0);
    check("rst_err",    32'(timeout_err), 32'd0);
    mute = 1'b0;
    do_reset();
    repeat (2) cycle();

    // random traffic with occasional aborts
    fixed_lat = -1;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!mv[i]) begin
          if ($urandom_range(0, 2) == 0) new_req(i);
        end else if (owner == i && $urandom_range(0, 19) == 0) begin
          mv[i] = 1'b0;
        end
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
